toy_bpu_tage_entry_buf: RTL and testbench



---
 rtl/toy_pack.sv | 54 +++++
 rtl/toy_bpu_tage_entry_buf.sv | 166 ++++++++++++++++
 tb/tb_toy_bpu_tage_entry_buf.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toy_pack.sv
// Shared TAGE parameters and payload types used by the entry buffer and the
// TAGE update port.
package toy_pack;

    localparam int TAGE_TABLE_NUM        = 4;
    localparam int TAGE_TX_INDEX_WIDTH   = 8;
    localparam int TAGE_TX_TAG_WIDTH     = 8;
    localparam int TAGE_BASE_INDEX_WIDTH = 10;

    // Per-table state captured at lookup time.
    typedef struct packed {
        logic       valid;
        logic [2:0] pred_cnt;
        logic [1:0] u_cnt;
    } tage_tx_snap_t;

    // Lookup snapshot handed over by BP decode.
    typedef struct packed {
        logic [TAGE_BASE_INDEX_WIDTH-1:0]                         tb_idx;
        logic [1:0]                                               tb_pred;
        logic [TAGE_TABLE_NUM-1:0][TAGE_TX_INDEX_WIDTH-1:0]       tx_hash_idx;
        logic [TAGE_TABLE_NUM-1:0][TAGE_TX_TAG_WIDTH-1:0]         tx_hash_tag;
        tage_tx_snap_t [TAGE_TABLE_NUM-1:0]                       tx_entry;
    } tage_pkg;

    // One tagged-table entry as written back by the update port.
    typedef struct packed {
        logic                           valid;
        logic [TAGE_TX_INDEX_WIDTH-1:0] index;
        logic [TAGE_TX_TAG_WIDTH-1:0]   tag;
        logic [2:0]                     pred_cnt;
        logic [1:0]                     u_cnt;
    } tage_tx_upd_t;

    typedef struct packed {
        logic [TAGE_BASE_INDEX_WIDTH-1:0]   tb_idx;
        logic [1:0]                         tb_pred;
        logic [TAGE_TABLE_NUM:0]            prvd_idx;
        tage_tx_upd_t [TAGE_TABLE_NUM-1:0]  tx_entry;
    } tage_upd_entry_t;

    typedef struct packed {
        logic                      taken;
        logic                      mispred;
        logic [TAGE_TABLE_NUM-1:0] alloc_id;
    } tage_upd_info_t;

    // Complete update request presented to the TAGE tables.
    typedef struct packed {
        tage_upd_entry_t entry;
        tage_upd_info_t  update;
    } tage_entry_buffer_pkg;

endpackage

// File: rtl/toy_bpu_tage_entry_buf.sv
// In-order buffer holding TAGE lookup snapshots from prediction until branch
// resolution, then issuing one table update per entry in push order.
module toy_bpu_tage_entry_buf
    import toy_pack::*;
#(
    parameter int DEPTH = 8,
    parameter int ID_W  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pred_vld,
    output logic                    pred_rdy,
    input  tage_pkg                 pred_pld,
    input  logic [TAGE_TABLE_NUM:0] pred_prvd,
    input  logic                    pred_taken,
    output logic [ID_W-1:0]         pred_id,
    input  logic                    resolve_vld,
    input  logic [ID_W-1:0]         resolve_id,
    input  logic                    resolve_taken,
    output logic                    upd_req,
    input  logic                    upd_ack,
    output tage_entry_buffer_pkg    upd_pld,
    input  logic                    flush
);

    localparam int N = TAGE_TABLE_NUM;
    localparam logic [ID_W:0] PTR_ONE = 1;

    typedef struct packed {
        tage_pkg    snap;
        logic [N:0] prvd;
        logic       pred_taken;
    } slot_t;

    slot_t            slot_q [DEPTH];
    logic [DEPTH-1:0] alloc_q;
    logic [DEPTH-1:0] res_q;
    logic [DEPTH-1:0] act_q;
    logic [ID_W:0]    head_q;
    logic [ID_W:0]    tail_q;

    logic [ID_W-1:0]  head_idx;
    logic [ID_W-1:0]  tail_idx;
    logic             full;
    logic             push_fire;
    logic             pop_fire;
    logic             resolve_ok;

    slot_t            head_slot;
    logic             head_act;
    logic             head_mispred;
    logic [N-1:0]     alloc_sel;
    logic             alloc_found;
    logic             above;

    // Saturating step of the 3-bit direction counter.
    function automatic logic [2:0] sat3(input logic [2:0] c, input logic up);
        if (up) return (c == 3'd7) ? c : c + 3'd1;
        else    return (c == 3'd0) ? c : c - 3'd1;
    endfunction

    // Saturating step of a 2-bit counter (base prediction or usefulness).
    function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
        if (up) return (c == 2'd3) ? c : c + 2'd1;
        else    return (c == 2'd0) ? c : c - 2'd1;
    endfunction

    assign head_idx   = head_q[ID_W-1:0];
    assign tail_idx   = tail_q[ID_W-1:0];
    assign full       = (head_q[ID_W] != tail_q[ID_W]) && (head_idx == tail_idx);
    assign pred_rdy   = ~full;
    assign pred_id    = tail_idx;
    assign push_fire  = pred_vld & ~full;
    assign upd_req    = alloc_q[head_idx] & res_q[head_idx];
    assign pop_fire   = upd_req & upd_ack;
    // A slot already resolved keeps its first outcome; stale ids are dropped.
    assign resolve_ok = resolve_vld & alloc_q[resolve_id] & ~res_q[resolve_id];

    assign head_slot    = slot_q[head_idx];
    assign head_act     = act_q[head_idx];
    assign head_mispred = head_act ^ head_slot.pred_taken;

    // Pointer and per-slot flag bookkeeping; flush and reset both empty the buffer.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every read in
        // this block sees the pre-edge value regardless of statement order.
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            alloc_q <= '0;
            res_q   <= '0;
            act_q   <= '0;
        end else begin
            // Push, resolve and pop never hit the same slot in one cycle:
            // the pushed slot is unallocated and the popped slot is resolved.
            if (push_fire) begin
                alloc_q[tail_idx] <= 1'b1;
                res_q[tail_idx]   <= 1'b0;
                tail_q            <= tail_q + PTR_ONE;
            end
            if (resolve_ok) begin
                res_q[resolve_id] <= 1'b1;
                act_q[resolve_id] <= resolve_taken;
            end
            if (pop_fire) begin
                alloc_q[head_idx] <= 1'b0;
                head_q            <= head_q + PTR_ONE;
            end
        end
    end

    // Snapshot storage written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        // NOTE: the payload array is reset as well so upd_pld reads as an
        // all-zero slot after reset; flush leaves it alone since the flags
        // already mark every slot empty.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
        end else if (push_fire && !flush) begin
            slot_q[tail_idx] <= '{snap: pred_pld, prvd: pred_prvd, pred_taken: pred_taken};
        end
    end

    // Pick the lowest table above the provider that is free or not useful.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (no latch).
        alloc_sel   = '0;
        alloc_found = 1'b0;
        above       = 1'b0;
        for (int j = 0; j < N; j++) begin
            // Table Tj sits above the provider if base..T(j-1) holds the provider bit.
            above = above | head_slot.prvd[j];
            if (!alloc_found && above &&
                (!head_slot.snap.tx_entry[j].valid || head_slot.snap.tx_entry[j].u_cnt == 2'd0)) begin
                alloc_sel[j] = 1'b1;
                alloc_found  = 1'b1;
            end
        end
    end

    // Build the update payload from the head slot and its resolved outcome.
    always_comb begin
        upd_pld                 = '0;
        upd_pld.update.taken    = head_act;
        upd_pld.update.mispred  = head_mispred;
        upd_pld.update.alloc_id = head_mispred ? alloc_sel : '0;
        upd_pld.entry.tb_idx    = head_slot.snap.tb_idx;
        upd_pld.entry.prvd_idx  = head_slot.prvd;
        upd_pld.entry.tb_pred   = head_slot.prvd[0] ? sat2(head_slot.snap.tb_pred, head_act)
                                                    : head_slot.snap.tb_pred;
        for (int i = 0; i < N; i++) begin
            upd_pld.entry.tx_entry[i].valid = head_slot.snap.tx_entry[i].valid;
            upd_pld.entry.tx_entry[i].index = head_slot.snap.tx_hash_idx[i];
            upd_pld.entry.tx_entry[i].tag   = head_slot.snap.tx_hash_tag[i];
            if (head_slot.prvd[i+1]) begin
                upd_pld.entry.tx_entry[i].pred_cnt = sat3(head_slot.snap.tx_entry[i].pred_cnt, head_act);
                upd_pld.entry.tx_entry[i].u_cnt    = sat2(head_slot.snap.tx_entry[i].u_cnt, !head_mispred);
            end else begin
                upd_pld.entry.tx_entry[i].pred_cnt = head_slot.snap.tx_entry[i].pred_cnt;
                upd_pld.entry.tx_entry[i].u_cnt    = head_slot.snap.tx_entry[i].u_cnt;
            end
        end
    end

endmodule

// File: tb/tb_toy_bpu_tage_entry_buf.sv
// Directed bench for the TAGE entry buffer: expected update payloads are
// queued when entries are pushed and matched by a monitor on each handshake.
module tb_toy_bpu_tage_entry_buf;
    import toy_pack::*;

    localparam int N = TAGE_TABLE_NUM;

    logic                 clk;
    logic                 rst;
    logic                 pred_vld;
    logic                 pred_rdy;
    tage_pkg              pred_pld;
    logic [N:0]           pred_prvd;
    logic                 pred_taken;
    logic [2:0]           pred_id;
    logic                 resolve_vld;
    logic [2:0]           resolve_id;
    logic                 resolve_taken;
    logic                 upd_req;
    logic                 upd_ack;
    tage_entry_buffer_pkg upd_pld;
    logic                 flush;

    int total = 0;
    int bad   = 0;
    tage_entry_buffer_pkg exp_q[$];

    toy_bpu_tage_entry_buf #(.DEPTH(8), .ID_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .pred_vld      (pred_vld),
        .pred_rdy      (pred_rdy),
        .pred_pld      (pred_pld),
        .pred_prvd     (pred_prvd),
        .pred_taken    (pred_taken),
        .pred_id       (pred_id),
        .resolve_vld   (resolve_vld),
        .resolve_id    (resolve_id),
        .resolve_taken (resolve_taken),
        .upd_req       (upd_req),
        .upd_ack       (upd_ack),
        .upd_pld       (upd_pld),
        .flush         (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_pld(input string name, input tage_entry_buffer_pkg act,
                             input tage_entry_buffer_pkg exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Snapshot with hash index seed+i and hash tag seed+0x40+i for table i.
    function automatic tage_pkg mk_snap(input logic [9:0] tbi, input logic [1:0] tbp,
                                        input logic [3:0] vld, input logic [11:0] pcs,
                                        input logic [7:0] us, input logic [7:0] seed);
        tage_pkg s;
        s         = '0;
        s.tb_idx  = tbi;
        s.tb_pred = tbp;
        for (int i = 0; i < N; i++) begin
            s.tx_hash_idx[i]       = seed + 8'(i);
            s.tx_hash_tag[i]       = seed + 8'h40 + 8'(i);
            s.tx_entry[i].valid    = vld[i];
            s.tx_entry[i].pred_cnt = pcs[3*i +: 3];
            s.tx_entry[i].u_cnt    = us[2*i +: 2];
        end
        return s;
    endfunction

    // Expected payload from hand-computed counter values.
    function automatic tage_entry_buffer_pkg mk_exp(input logic [9:0] tbi, input logic [1:0] tbp,
                                                    input logic [4:0] prvd, input logic [3:0] vld,
                                                    input logic [11:0] pcs, input logic [7:0] us,
                                                    input logic [7:0] seed, input logic taken,
                                                    input logic misp, input logic [3:0] alloc);
        tage_entry_buffer_pkg e;
        e                 = '0;
        e.entry.tb_idx    = tbi;
        e.entry.tb_pred   = tbp;
        e.entry.prvd_idx  = prvd;
        for (int i = 0; i < N; i++) begin
            e.entry.tx_entry[i].valid    = vld[i];
            e.entry.tx_entry[i].index    = seed + 8'(i);
            e.entry.tx_entry[i].tag      = seed + 8'h40 + 8'(i);
            e.entry.tx_entry[i].pred_cnt = pcs[3*i +: 3];
            e.entry.tx_entry[i].u_cnt    = us[2*i +: 2];
        end
        e.update.taken    = taken;
        e.update.mispred  = misp;
        e.update.alloc_id = alloc;
        return e;
    endfunction

    // Fill entries: provider T2, all pred_cnt 3, all u_cnt 1, predicted and actual taken.
    function automatic tage_pkg fill_snap(input int k);
        return mk_snap(10'h100 + 10'(k), 2'd1, 4'hF, {3'd3, 3'd3, 3'd3, 3'd3}, 8'h55, 8'h40 + 8'(k * 8));
    endfunction

    function automatic tage_entry_buffer_pkg fill_exp(input int k);
        return mk_exp(10'h100 + 10'(k), 2'd1, 5'b01000, 4'hF, {3'd3, 3'd4, 3'd3, 3'd3},
                      {2'd1, 2'd2, 2'd1, 2'd1}, 8'h40 + 8'(k * 8), 1'b1, 1'b0, 4'b0000);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input tage_pkg s, input logic [4:0] prvd, input logic pt,
                        input int exp_id, input bit enq, input tage_entry_buffer_pkg e);
        check("push_rdy", 32'(pred_rdy), 32'd1);
        check("push_id", 32'(pred_id), 32'(exp_id));
        pred_vld   = 1'b1;
        pred_pld   = s;
        pred_prvd  = prvd;
        pred_taken = pt;
        if (enq) exp_q.push_back(e);
        tick();
        pred_vld = 1'b0;
    endtask

    task automatic resolve(input int id, input logic taken);
        resolve_vld   = 1'b1;
        resolve_id    = 3'(id);
        resolve_taken = taken;
        tick();
        resolve_vld = 1'b0;
    endtask

    // Scoreboard monitor: every accepted update must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && upd_req && upd_ack) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL upd_unexpected: got %h want none", upd_pld);
            end else begin
                check_pld("upd_pld", upd_pld, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tage_pkg              snap_a, snap_b, snap_s, snap_t;
        tage_entry_buffer_pkg exp_a, exp_b, exp_s, exp_t, exp1;

        rst = 1'b1; flush = 1'b0; pred_vld = 1'b0; pred_pld = '0; pred_prvd = '0;
        pred_taken = 1'b0; resolve_vld = 1'b0; resolve_id = '0; resolve_taken = 1'b0;
        upd_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", 32'(pred_rdy), 32'd1);
        check("rst_id", 32'(pred_id), 32'd0);
        check("rst_req", 32'(upd_req), 32'd0);
        check_pld("rst_pld", upd_pld, '0);
        rst = 1'b0;
        tick();

        // Single correct prediction, provider T1.
        exp1 = mk_exp(10'h155, 2'd2, 5'b00100, 4'hF, {3'd2, 3'd1, 3'd4, 3'd5},
                      {2'd3, 2'd0, 2'd2, 2'd1}, 8'h10, 1'b1, 1'b0, 4'b0000);
        push(mk_snap(10'h155, 2'd2, 4'hF, {3'd2, 3'd1, 3'd3, 3'd5}, {2'd3, 2'd0, 2'd1, 2'd1}, 8'h10),
             5'b00100, 1'b1, 0, 1'b1, exp1);
        check("t1_req_unresolved", 32'(upd_req), 32'd0);
        resolve(0, 1'b1);
        check("t1_req", 32'(upd_req), 32'd1);
        check_pld("t1_pld", upd_pld, exp1);
        upd_ack = 1'b1;
        tick();
        upd_ack = 1'b0;
        check("t1_req_after_pop", 32'(upd_req), 32'd0);
        check("t1_id_after_pop", 32'(pred_id), 32'd1);

        // Mispredict: provider T0 allocates T2; provider T3 allocates nothing.
        snap_a = mk_snap(10'h0A3, 2'd1, 4'hF, {3'd7, 3'd6, 3'd2, 3'd4}, {2'd1, 2'd0, 2'd2, 2'd1}, 8'h20);
        exp_a  = mk_exp(10'h0A3, 2'd1, 5'b00010, 4'hF, {3'd7, 3'd6, 3'd2, 3'd3},
                        {2'd1, 2'd0, 2'd2, 2'd0}, 8'h20, 1'b0, 1'b1, 4'b0100);
        snap_b = mk_snap(10'h0B4, 2'd1, 4'hF, {3'd7, 3'd6, 3'd2, 3'd4}, {2'd1, 2'd0, 2'd2, 2'd1}, 8'h30);
        exp_b  = mk_exp(10'h0B4, 2'd1, 5'b10000, 4'hF, {3'd6, 3'd6, 3'd2, 3'd4},
                        {2'd0, 2'd0, 2'd2, 2'd1}, 8'h30, 1'b0, 1'b1, 4'b0000);
        push(snap_a, 5'b00010, 1'b1, 1, 1'b1, exp_a);
        push(snap_b, 5'b10000, 1'b1, 2, 1'b1, exp_b);
        resolve(2, 1'b0);
        check("t2_req_head_unresolved", 32'(upd_req), 32'd0);
        resolve(1, 1'b0);
        check("t2_req", 32'(upd_req), 32'd1);
        upd_ack = 1'b1;
        tick();
        check("t2_req_second", 32'(upd_req), 32'd1);
        tick();
        upd_ack = 1'b0;
        check("t2_req_drained", 32'(upd_req), 32'd0);

        // Fill to full from a flushed, empty buffer.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3_flush_id", 32'(pred_id), 32'd0);
        for (int k = 0; k < 8; k++) push(fill_snap(k), 5'b01000, 1'b1, k, 1'b1, fill_exp(k));
        check("t3_full_rdy", 32'(pred_rdy), 32'd0);
        check("t3_full_id", 32'(pred_id), 32'd0);

        // Out-of-order resolve: nothing issues until slot 0 resolves.
        resolve(2, 1'b1);
        check("t4_req_after_2", 32'(upd_req), 32'd0);
        resolve(1, 1'b1);
        check("t4_req_after_1", 32'(upd_req), 32'd0);
        resolve(0, 1'b1);
        check("t4_req_after_0", 32'(upd_req), 32'd1);

        // Push while full alongside a pop: pop happens, push is refused.
        pred_vld   = 1'b1;
        pred_pld   = fill_snap(8);
        pred_prvd  = 5'b01000;
        pred_taken = 1'b1;
        upd_ack    = 1'b1;
        tick();
        pred_vld = 1'b0;
        upd_ack  = 1'b0;
        check("t3_rdy_after_pop", 32'(pred_rdy), 32'd1);
        check("t3_id_no_push", 32'(pred_id), 32'd0);
        check("t3_req_slot1", 32'(upd_req), 32'd1);
        push(fill_snap(8), 5'b01000, 1'b1, 0, 1'b1, fill_exp(8));
        check("t3_wrap_id", 32'(pred_id), 32'd1);
        check("t3_wrap_full", 32'(pred_rdy), 32'd0);
        upd_ack = 1'b1;
        repeat (2) tick();
        upd_ack = 1'b0;
        check("t4_req_slot3_unresolved", 32'(upd_req), 32'd0);
        check("t4_rdy", 32'(pred_rdy), 32'd1);
        for (int id = 3; id < 8; id++) resolve(id, 1'b1);
        resolve(0, 1'b1);
        upd_ack = 1'b1;
        repeat (6) tick();
        upd_ack = 1'b0;
        check("t4_req_empty", 32'(upd_req), 32'd0);
        check("t4_id_end", 32'(pred_id), 32'd1);

        // Flush overriding push and resolve with 5 entries, 3 resolved.
        for (int k = 0; k < 5; k++) push(fill_snap(k), 5'b01000, 1'b1, k + 1, 1'b0, fill_exp(k));
        resolve(1, 1'b1);
        resolve(2, 1'b0);
        resolve(3, 1'b1);
        check("t5_req_before_flush", 32'(upd_req), 32'd1);
        flush         = 1'b1;
        pred_vld      = 1'b1;
        pred_pld      = fill_snap(9);
        resolve_vld   = 1'b1;
        resolve_id    = 3'd4;
        resolve_taken = 1'b1;
        tick();
        flush = 1'b0; pred_vld = 1'b0; resolve_vld = 1'b0;
        check("t5_req", 32'(upd_req), 32'd0);
        check("t5_id", 32'(pred_id), 32'd0);
        check("t5_rdy", 32'(pred_rdy), 32'd1);
        resolve(1, 1'b1);
        check("t5_stale_resolve", 32'(upd_req), 32'd0);
        check("t5_stale_id", 32'(pred_id), 32'd0);

        // Base-provider saturation at both ends, and a stalled consumer.
        snap_s = mk_snap(10'h3FF, 2'd3, 4'hF, {3'd1, 3'd2, 3'd3, 3'd4}, 8'h55, 8'h80);
        exp_s  = mk_exp(10'h3FF, 2'd3, 5'b00001, 4'hF, {3'd1, 3'd2, 3'd3, 3'd4},
                        8'h55, 8'h80, 1'b1, 1'b0, 4'b0000);
        snap_t = mk_snap(10'h011, 2'd0, 4'b1110, {3'd0, 3'd7, 3'd0, 3'd7}, 8'hFF, 8'hC0);
        exp_t  = mk_exp(10'h011, 2'd0, 5'b00001, 4'b1110, {3'd0, 3'd7, 3'd0, 3'd7},
                        8'hFF, 8'hC0, 1'b0, 1'b1, 4'b0001);
        push(snap_s, 5'b00001, 1'b1, 0, 1'b1, exp_s);
        push(snap_t, 5'b00001, 1'b1, 1, 1'b1, exp_t);
        resolve(0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            check("t6_stall_req", 32'(upd_req), 32'd1);
            check_pld("t6_stall_pld", upd_pld, exp_s);
            if (c == 2) resolve(1, 1'b0);
            else        tick();
        end
        upd_ack = 1'b1;
        repeat (2) tick();
        upd_ack = 1'b0;
        check("t6_req_drained", 32'(upd_req), 32'd0);

        // Reset in the middle of operation.
        push(snap_s, 5'b00001, 1'b1, 2, 1'b0, exp_s);
        resolve(2, 1'b1);
        check("t7_req_before_rst", 32'(upd_req), 32'd1);
        rst = 1'b1;
        tick();
        check("t7_req", 32'(upd_req), 32'd0);
        check("t7_id", 32'(pred_id), 32'd0);
        check("t7_rdy", 32'(pred_rdy), 32'd1);
        check_pld("t7_pld", upd_pld, '0);
        rst = 1'b0;
        tick();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
